// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// seq_pkg : shared types and default widths for the sequence point scheduler
// Rev 1.0
// ============================================================================
package seq_pkg;

  localparam int SEQ_IDX_W = 16;
  localparam int SEQ_DIV_W = 16;

  typedef enum logic [1:0] {
    SEQ_LOOP     = 2'd0,
    SEQ_ONESHOT  = 2'd1,
    SEQ_PINGPONG = 2'd2,
    SEQ_RSVD     = 2'd3
  } seq_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  function automatic seq_mode_t to_mode(input logic [1:0] raw);
    return seq_mode_t'(raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tick_divider.sv
`default_nettype none
// ============================================================================
// seq_tick_divider : counts reference ticks, pulses adv every DIV ticks
// Rev 1.0
// ============================================================================
module seq_tick_divider
  import seq_pkg::*;
#(
  parameter int DIV_W = SEQ_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
  output logic             adv
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A divider of 0 behaves as 1, so the last count is 0 in both cases.
  assign last_cnt = (div == '0) ? '0 : div - 1'b1;
  assign adv      = tick && !clr && (div_cnt_q >= last_cnt);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (tick) begin
      div_cnt_d = adv ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_point_scheduler.sv
`default_nettype none
// ============================================================================
// seq_point_scheduler : SYNC-aligned sequence point index with fetch handshake
// Rev 1.0
// ============================================================================
module seq_point_scheduler
  import seq_pkg::*;
#(
  parameter int IDX_W = SEQ_IDX_W,
  parameter int DIV_W = SEQ_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             ref_clk_tick,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cycle,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  output logic [IDX_W-1:0] idx,
  output logic             step,
  output logic             wrap,
  output logic             done,
  output logic             req,
  output logic [IDX_W-1:0] req_idx,
  input  logic             ack,
  output logic             overrun,
  output logic             cfg_pending
);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_up_q, dir_up_d;
  logic             done_q, done_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             req_q, req_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic             overrun_q, overrun_d;
  logic             cfg_pending_q, cfg_pending_d;

  logic [IDX_W-1:0] act_cycle_q, act_cycle_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  seq_mode_t        act_mode_q, act_mode_d;
  logic [IDX_W-1:0] shd_cycle_q, shd_cycle_d;
  logic [DIV_W-1:0] shd_div_q, shd_div_d;
  seq_mode_t        shd_mode_q, shd_mode_d;

  logic             div_tick;
  logic             adv;
  logic [IDX_W-1:0] adv_idx;
  logic             adv_dir_up;
  logic             adv_step;
  logic             adv_wrap;
  logic             adv_done;

  // Ticks only count while running; SYNC and EN low both take precedence.
  assign div_tick = ref_clk_tick && en && !sync && (state_q == RUN);

  seq_tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sync),
    .tick  (div_tick),
    .div   (act_div_q),
    .adv   (adv)
  );

  // Next index for one divider advance under the active playback mode.
  always_comb begin
    adv_idx    = idx_q;
    adv_dir_up = dir_up_q;
    adv_step   = 1'b0;
    adv_wrap   = 1'b0;
    adv_done   = 1'b0;
    unique case (act_mode_q)
      SEQ_ONESHOT: begin
        if (idx_q == act_cycle_q) begin
          adv_done = 1'b1;
        end else begin
          adv_idx  = idx_q + 1'b1;
          adv_step = 1'b1;
          adv_done = (adv_idx == act_cycle_q);
        end
      end
      SEQ_PINGPONG: begin
        adv_step = 1'b1;
        if (act_cycle_q == '0) begin
          adv_idx = '0;
        end else if (dir_up_q) begin
          if (idx_q == act_cycle_q) begin
            adv_dir_up = 1'b0;
            adv_idx    = idx_q - 1'b1;
          end else begin
            adv_idx = idx_q + 1'b1;
          end
        end else begin
          if (idx_q == '0) begin
            adv_dir_up = 1'b1;
            adv_idx    = idx_q + 1'b1;
          end else begin
            adv_idx = idx_q - 1'b1;
          end
        end
        adv_wrap = (adv_idx == '0);
      end
      default: begin
        adv_step = 1'b1;
        if (idx_q == act_cycle_q) begin
          adv_idx  = '0;
          adv_wrap = 1'b1;
        end else begin
          adv_idx = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dir_up_d      = dir_up_q;
    done_d        = done_q;
    step_d        = 1'b0;
    wrap_d        = 1'b0;
    req_d         = req_q;
    req_idx_d     = req_idx_q;
    overrun_d     = overrun_q;
    cfg_pending_d = cfg_pending_q;
    act_cycle_d   = act_cycle_q;
    act_div_d     = act_div_q;
    act_mode_d    = act_mode_q;
    shd_cycle_d   = shd_cycle_q;
    shd_div_d     = shd_div_q;
    shd_mode_d    = shd_mode_q;

    if (req_q && ack) begin
      req_d = 1'b0;
    end

    if (cfg_we) begin
      shd_cycle_d   = cycle;
      shd_div_d     = div;
      shd_mode_d    = to_mode(mode);
      cfg_pending_d = 1'b1;
    end

    if (sync) begin
      // A write coinciding with SYNC bypasses the shadow and applies at once.
      if (cfg_we) begin
        act_cycle_d = cycle;
        act_div_d   = div;
        act_mode_d  = to_mode(mode);
      end else if (cfg_pending_q) begin
        act_cycle_d = shd_cycle_q;
        act_div_d   = shd_div_q;
        act_mode_d  = shd_mode_q;
      end
      cfg_pending_d = 1'b0;
      idx_d         = '0;
      done_d        = 1'b0;
      dir_up_d      = 1'b1;
      overrun_d     = 1'b0;
      if (en) begin
        state_d   = RUN;
        step_d    = 1'b1;
        req_d     = 1'b1;
        req_idx_d = '0;
      end else begin
        state_d = IDLE;
      end
    end else if (!en) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (adv) begin
      dir_up_d = adv_dir_up;
      if (adv_step) begin
        idx_d     = adv_idx;
        step_d    = 1'b1;
        wrap_d    = adv_wrap;
        req_d     = 1'b1;
        req_idx_d = adv_idx;
        // An ACK in the same cycle retires the old request cleanly.
        if (req_q && !ack) begin
          overrun_d = 1'b1;
        end
      end
      if (adv_done) begin
        done_d  = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dir_up_q      <= 1'b1;
      done_q        <= 1'b0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      req_q         <= 1'b0;
      req_idx_q     <= '0;
      overrun_q     <= 1'b0;
      cfg_pending_q <= 1'b0;
      act_cycle_q   <= '0;
      act_div_q     <= DIV_W'(1);
      act_mode_q    <= SEQ_LOOP;
      shd_cycle_q   <= '0;
      shd_div_q     <= '0;
      shd_mode_q    <= SEQ_LOOP;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dir_up_q      <= dir_up_d;
      done_q        <= done_d;
      step_q        <= step_d;
      wrap_q        <= wrap_d;
      req_q         <= req_d;
      req_idx_q     <= req_idx_d;
      overrun_q     <= overrun_d;
      cfg_pending_q <= cfg_pending_d;
      act_cycle_q   <= act_cycle_d;
      act_div_q     <= act_div_d;
      act_mode_q    <= act_mode_d;
      shd_cycle_q   <= shd_cycle_d;
      shd_div_q     <= shd_div_d;
      shd_mode_q    <= shd_mode_d;
    end
  end

  assign idx         = idx_q;
  assign step        = step_q;
  assign wrap        = wrap_q;
  assign done        = done_q;
  assign req         = req_q;
  assign req_idx     = req_idx_q;
  assign overrun     = overrun_q;
  assign cfg_pending = cfg_pending_q;

endmodule
`default_nettype wire
